vregfile_arbiter: RTL

VREGFILE_ARBITER -- requirements
Module: vregfile_arbiter

---
 rtl/vregfile_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/vregfile_arbiter.sv
// Two-port access arbiter for a vector register file: independent 2-way round-robin
// arbitration of the read and write ports, 1-cycle read return with write-to-read bypass.
module vregfile_arbiter #(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 16,
    parameter int LOG2NUMREGS = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [1:0]             rd_req,
    input  logic [LOG2NUMREGS-1:0] rd_reg0,
    input  logic [LOG2NUMREGS-1:0] rd_reg1,
    output logic [1:0]             rd_gnt,
    output logic                   rd_valid,
    output logic                   rd_id,
    output logic [WIDTH-1:0]       rd_data,
    input  logic [1:0]             wr_req,
    input  logic [LOG2NUMREGS-1:0] wr_reg0,
    input  logic [LOG2NUMREGS-1:0] wr_reg1,
    input  logic [WIDTH-1:0]       wr_data0,
    input  logic [WIDTH-1:0]       wr_data1,
    output logic [1:0]             wr_gnt,
    output logic [LOG2NUMREGS-1:0] a_reg,
    output logic                   a_en,
    input  logic [WIDTH-1:0]       a_readdataout,
    output logic [LOG2NUMREGS-1:0] c_reg,
    output logic [WIDTH-1:0]       c_writedatain,
    output logic                   c_we
);

    if (NUMREGS > (1 << LOG2NUMREGS)) begin : g_bad_params
        $error("NUMREGS does not fit in LOG2NUMREGS address bits");
    end

    // Pointer value is the agent that wins when both request.
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_valid_q;
    logic             rd_id_q;
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;

    always_comb begin
        rd_gnt = 2'b00;
        if (resetn) begin
            case (rd_req)
                2'b01:   rd_gnt = 2'b01;
                2'b10:   rd_gnt = 2'b10;
                2'b11:   rd_gnt = rd_ptr_q ? 2'b10 : 2'b01;
                default: rd_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        wr_gnt = 2'b00;
        if (resetn) begin
            case (wr_req)
                2'b01:   wr_gnt = 2'b01;
                2'b10:   wr_gnt = 2'b10;
                2'b11:   wr_gnt = wr_ptr_q ? 2'b10 : 2'b01;
                default: wr_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_gnt[0])      rd_ptr_d = 1'b1;
        else if (rd_gnt[1]) rd_ptr_d = 1'b0;
        wr_ptr_d = wr_ptr_q;
        if (wr_gnt[0])      wr_ptr_d = 1'b1;
        else if (wr_gnt[1]) wr_ptr_d = 1'b0;
    end

    always_comb begin
        a_en          = |rd_gnt;
        a_reg         = rd_gnt[1] ? rd_reg1 : (rd_gnt[0] ? rd_reg0 : '0);
        c_we          = |wr_gnt;
        c_reg         = wr_gnt[1] ? wr_reg1 : (wr_gnt[0] ? wr_reg0 : '0);
        c_writedatain = wr_gnt[1] ? wr_data1 : (wr_gnt[0] ? wr_data0 : '0);
    end

    // The RAM returns stale data on a same-address read/write, so capture the write data.
    always_comb begin
        byp_d      = a_en && c_we && (a_reg == c_reg);
        byp_data_d = byp_d ? c_writedatain : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_valid_q <= a_en;
            rd_id_q    <= rd_gnt[1];
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    always_comb begin
        rd_valid = rd_valid_q;
        rd_id    = rd_valid_q & rd_id_q;
        rd_data  = '0;
        if (rd_valid_q) rd_data = byp_q ? byp_data_q : a_readdataout;
    end

endmodule
